// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   pipe_state_t : sequencer mode (normal run, draining, one-cycle flush)
//   occ_width()  : bits needed to hold an occupancy count of 0..stages
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_t;

  // Occupancy ranges over 0..stages inclusive, hence the +1.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one event this cycle
//   count      : current value, sticks at all-ones once reached
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear first, then increment only while below the all-ones ceiling so the
  // counter parks at its maximum instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Control sequencer for a STAGES-deep register pipeline whose data registers
// live outside this block and are clock-enabled by stage_en.  Tracks a valid
// bit per stage with bubble collapsing, supports drain and flush, and keeps
// stall/transfer statistics.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake into stage 0
//   out_valid / out_ready : downstream handshake from the last stage
//   flush                 : discard everything in flight (one FLUSH cycle follows)
//   drain_req, drain_done : level request to stop intake and empty; done pulse
//   stage_en              : per-stage load enable for the data registers
//   stage_valid           : valid flag of each stage
//   occupancy             : number of valid stages
//   stall_cnt, xfer_cnt   : saturating stall / transfer counters
//   clr_stats             : synchronous clear of both counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 10,
  parameter int CW     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           flush,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic [STAGES-1:0]              stage_en,
  output logic [STAGES-1:0]              stage_valid,
  output logic [occ_width(STAGES)-1:0]   occupancy,
  output logic [CW-1:0]                  stall_cnt,
  output logic [CW-1:0]                  xfer_cnt,
  input  logic                           clr_stats
);

  localparam int OW = occ_width(STAGES);

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic [STAGES-1:0] rdy;
  logic              accept;
  logic              xfer;
  logic              stall;

  // Unrolled ready chain: a stage may load when it, or any stage downstream
  // of it, is empty, or when the output is being accepted.  Written as a
  // reduction over the downstream valid bits so no signal feeds itself.
  for (genvar i = 0; i < STAGES; i++) begin : g_rdy
    assign rdy[i] = out_ready | ~(&stage_valid[STAGES-1:i]);
  end

  assign in_ready  = (state_q == ST_RUN) & rdy[0];
  assign stage_en  = (state_q == ST_FLUSH) ? '0 : rdy;
  assign out_valid = stage_valid[STAGES-1];
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  // Next-state logic.  Flush overrides everything; a drain ends either when
  // the pipeline is empty (signalled by drain_done) or when the request drops.
  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (drain_req) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (occupancy == '0) begin
            state_d    = ST_RUN;
            drain_done = 1'b1;
          end else if (!drain_req) begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid bits and occupancy.  Each stage copies its upstream neighbour when
  // it is ready, so empty stages keep loading even while the tail is stalled.
  // Occupancy is tracked incrementally from the handshakes rather than by a
  // popcount; a flush (or the FLUSH cycle itself) empties everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      occupancy   <= '0;
    end else if (flush || (state_q == ST_FLUSH)) begin
      stage_valid <= '0;
      occupancy   <= '0;
    end else begin
      if (rdy[0]) stage_valid[0] <= accept;
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) stage_valid[i] <= stage_valid[i-1];
      end
      case ({accept, xfer})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Statistics.  A transfer in the same cycle as a flush still counts.
  pipe_sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (stall),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CW)) u_xfer_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (xfer),
    .count (xfer_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl.  A behavioural model tracks which pipeline
// slots hold items, the sequencer mode and the statistics; a data scoreboard
// checks items leave in order through registers clocked by stage_en.
module tb_pipe_ctrl;

  localparam int STAGES = 10;
  localparam int CW     = 6;
  localparam int OW     = $clog2(STAGES + 1);
  localparam int SAT    = (1 << CW) - 1;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_FLUSH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic              drain_req = 1'b0;
  logic              clr_stats = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              drain_done;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_valid;
  logic [OW-1:0]     occupancy;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     xfer_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(STAGES), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .stage_en    (stage_en),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt),
    .xfer_cnt    (xfer_cnt),
    .clr_stats   (clr_stats)
  );

  // External data registers, loaded only through stage_en.
  logic [7:0] in_data = 8'd0;
  logic [7:0] data_q [STAGES];

  always @(posedge clk) begin
    if (stage_en[0]) data_q[0] <= in_data;
    for (int i = 1; i < STAGES; i++) begin
      if (stage_en[i]) data_q[i] <= data_q[i-1];
    end
  end

  // Model state.
  bit         m_valid [STAGES];
  int         m_mode;
  int         m_stall;
  int         m_xfer;
  logic [7:0] sb_q [$];

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic obs_ir, obs_ov, obs_dd;
  int   obs_occ, obs_stall;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < STAGES; i++) m_valid[i] = 1'b0;
    m_mode  = M_RUN;
    m_stall = 0;
    m_xfer  = 0;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare every output
  // with the model, advance the model, then wait for the next falling edge.
  task automatic applyStimulus(input bit iv, input bit ordy, input bit fl, input bit dr, input bit clr);
    bit                en [STAGES];
    bit                take;
    bit                m_ir, m_ov, m_dd, acc, xf;
    int                occ;
    logic [STAGES-1:0] en_vec, v_vec;
    logic [7:0]        exp_data;

    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    drain_req = dr;
    clr_stats = clr;
    in_data   = 8'($urandom);
    #1;

    // A slot loads when it is empty or its occupant moves on.
    take = ordy;
    for (int i = STAGES - 1; i >= 0; i--) begin
      en[i] = !m_valid[i] || take;
      take  = en[i];
    end
    occ = 0;
    for (int i = 0; i < STAGES; i++) begin
      occ      += int'(m_valid[i]);
      en_vec[i] = (m_mode != M_FLUSH) && en[i];
      v_vec[i]  = m_valid[i];
    end
    m_ir = (m_mode == M_RUN) && en[0];
    m_ov = m_valid[STAGES-1];
    m_dd = (m_mode == M_DRAIN) && (occ == 0) && !fl;

    obs_ir    = in_ready;
    obs_ov    = out_valid;
    obs_dd    = drain_done;
    obs_occ   = int'(occupancy);
    obs_stall = int'(stall_cnt);

    checkOutput("in_ready",    32'(in_ready),    32'(m_ir));
    checkOutput("out_valid",   32'(out_valid),   32'(m_ov));
    checkOutput("drain_done",  32'(drain_done),  32'(m_dd));
    checkOutput("stage_en",    32'(stage_en),    32'(en_vec));
    checkOutput("stage_valid", 32'(stage_valid), 32'(v_vec));
    checkOutput("occupancy",   32'(occupancy),   32'(occ));
    checkOutput("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    checkOutput("xfer_cnt",    32'(xfer_cnt),    32'(m_xfer));

    acc = iv && m_ir;
    xf  = m_ov && ordy;
    if (xf && (sb_q.size() > 0)) begin
      exp_data = sb_q.pop_front();
      checkOutput("out_data", 32'(data_q[STAGES-1]), 32'(exp_data));
    end
    if (acc) sb_q.push_back(in_data);

    if (clr) begin
      m_stall = 0;
      m_xfer  = 0;
    end else begin
      if (m_ov && !ordy && (m_stall < SAT)) m_stall++;
      if (xf && (m_xfer < SAT)) m_xfer++;
    end

    if (fl || (m_mode == M_FLUSH)) begin
      for (int i = 0; i < STAGES; i++) m_valid[i] = 1'b0;
      sb_q.delete();
    end else begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        if (en[i]) m_valid[i] = m_valid[i-1];
      end
      if (en[0]) m_valid[0] = acc;
    end

    if (fl) begin
      m_mode = M_FLUSH;
    end else begin
      case (m_mode)
        M_RUN:   if (dr) m_mode = M_DRAIN;
        M_DRAIN: if ((occ == 0) || !dr) m_mode = M_RUN;
        default: m_mode = M_RUN;
      endcase
    end

    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stage_valid"}, 32'(stage_valid), 32'd0);
    checkOutput({tag, "_occupancy"},   32'(occupancy),   32'd0);
    checkOutput({tag, "_stall_cnt"},   32'(stall_cnt),   32'd0);
    checkOutput({tag, "_xfer_cnt"},    32'(xfer_cnt),    32'd0);
    checkOutput({tag, "_drain_done"},  32'(drain_done),  32'd0);
    checkOutput({tag, "_out_valid"},   32'(out_valid),   32'd0);
  endtask

  initial begin
    int first_ov, ov_count, run, max_run, peak;
    int dd_count;
    bit ir_seen;
    bit dr;

    $display("[TB] pipe_ctrl bench, STAGES=%0d CW=%0d", STAGES, CW);
    modelReset();
    #1;
    checkResetOutputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First cycle after reset, then clear stats before the latency test.
    applyStimulus(0, 1, 0, 0, 1);

    // Single item: exactly one out_valid cycle, STAGES cycles after acceptance.
    $display("[TB] single item latency");
    applyStimulus(1, 1, 0, 0, 0);
    first_ov = -1;
    ov_count = 0;
    for (int k = 1; k < 15; k++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (obs_ov && (first_ov < 0)) first_ov = k;
      ov_count += int'(obs_ov);
    end
    checkOutput("single_latency",  32'(first_ov), 32'd10);
    checkOutput("single_ov_count", 32'(ov_count), 32'd1);
    checkOutput("single_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // 20 back-to-back items with no back-pressure.
    $display("[TB] back-to-back stream");
    ov_count = 0; run = 0; max_run = 0; peak = 0;
    for (int k = 0; k < 34; k++) begin
      applyStimulus((k < 20), 1, 0, 0, 0);
      if (obs_ov) begin
        ov_count++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (obs_occ > peak) peak = obs_occ;
    end
    checkOutput("b2b_ov_count", 32'(ov_count), 32'd20);
    checkOutput("b2b_ov_run",   32'(max_run),  32'd20);
    checkOutput("b2b_peak_occ", 32'(peak),     32'd10);

    // Full pipeline held for 5 cycles of back-pressure.
    $display("[TB] full pipeline stall");
    for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    ir_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      ir_seen |= obs_ir;
    end
    checkOutput("stall_in_ready", 32'(ir_seen), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stall_cnt_5", 32'(obs_stall), 32'd5);
    for (int k = 0; k < 11; k++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stall_xfer_10", 32'(xfer_cnt), 32'd10);

    // Bubble collapse: items in stages 0 and 9, tail stalled.
    $display("[TB] bubble collapse");
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("bubble_start", 32'(stage_valid), 32'h201);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bubble_end", 32'(stage_valid), 32'h300);
    for (int k = 0; k < 12; k++) applyStimulus(0, 1, 0, 0, 0);

    // Drain from occupancy 4.
    $display("[TB] drain");
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("drain_occ_4", 32'(occupancy), 32'd4);
    applyStimulus(0, 1, 0, 1, 1);
    dr = 1'b1; dd_count = 0; ir_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      applyStimulus(dr, 1, 0, dr, 0);
      if (dr) ir_seen |= obs_ir;
      dd_count += int'(obs_dd);
      if (obs_dd) dr = 1'b0;
    end
    checkOutput("drain_in_ready", 32'(ir_seen),  32'd0);
    checkOutput("drain_dd_count", 32'(dd_count), 32'd1);
    checkOutput("drain_xfers",    32'(xfer_cnt), 32'd4);

    // Flush at occupancy 7 with a transfer in the same cycle.
    $display("[TB] flush with transfer");
    for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("flush_occ_7", 32'(occupancy),   32'd7);
    checkOutput("flush_sv",    32'(stage_valid), 32'h3F8);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("flush_sv_clear",  32'(stage_valid), 32'd0);
    checkOutput("flush_occ_clear", 32'(occupancy),   32'd0);
    checkOutput("flush_xfer",      32'(xfer_cnt),    32'd1);
    checkOutput("flush_in_ready",  32'(in_ready),    32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("flush_recover",   32'(in_ready),    32'd1);

    // Randomised traffic including flush, drain and stats clears.
    $display("[TB] random traffic");
    dr = 1'b0;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 19) == 0) dr = !dr;
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 39) == 0), dr, ($urandom_range(0, 63) == 0));
    end

    // Reset in the middle of a stream.
    $display("[TB] mid-stream reset");
    for (int k = 0; k < 6; k++) applyStimulus(1, ($urandom_range(0, 1) == 1), 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_rst");
    modelReset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) dr = !dr;
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 49) == 0), dr, ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
